// File: rtl/bus_pkg.sv
// Shared definitions for the external-bus responder and the core-side address decode.
package bus_pkg;

  localparam int          BUS_AW   = 10;
  localparam logic [15:0] BUS_BASE = 16'h0000;
  localparam int          BUS_WSW  = 3;
  localparam int          BUS_DW   = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_HOLD
  } state_e;

  typedef enum logic [1:0] {
    CYC_RD,
    CYC_WR,
    CYC_ERR
  } cyc_e;

endpackage

// File: rtl/bus_responder_if.sv
// Core-to-memory external bus: strobes, address/data and the completion handshake.
interface bus_responder_if #(
  parameter int WSW = 3
);
  logic [15:0]    ABUS;
  logic [15:0]    DBUS_W;
  logic [15:0]    DBUS_R;
  logic           DBUS_R_EN;
  logic           AOUTENX;
  logic           DOUTENX;
  logic           DINENX;
  logic [WSW-1:0] WAIT_STATES;
  logic           READY;
  logic           BUS_ERR;

  modport master (
    output ABUS, DBUS_W, AOUTENX, DOUTENX, DINENX, WAIT_STATES,
    input  DBUS_R, DBUS_R_EN, READY, BUS_ERR
  );

  modport slave (
    input  ABUS, DBUS_W, AOUTENX, DOUTENX, DINENX, WAIT_STATES,
    output DBUS_R, DBUS_R_EN, READY, BUS_ERR
  );
endinterface

// File: rtl/bus_ram.sv
// Single-port synchronous RAM with registered read data, written to infer block RAM.
module bus_ram
  import bus_pkg::*;
#(
  parameter int AW = BUS_AW,
  parameter int DW = BUS_DW
) (
  input  logic          CLK,
  input  logic          WE,
  input  logic [AW-1:0] ADDR,
  input  logic [DW-1:0] DIN,
  output logic [DW-1:0] DOUT
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  always_ff @(posedge CLK) begin
    if (WE) begin
      mem[ADDR] <= DIN;
    end
    DOUT <= mem[ADDR];
  end

endmodule

// File: rtl/bus_responder.sv
// Memory-side bus responder: decodes read/write cycles, inserts wait states,
// answers with READY/BUS_ERR and serves data from an internal RAM.
module bus_responder
  import bus_pkg::*;
#(
  parameter int          AW   = BUS_AW,
  parameter logic [15:0] BASE = BUS_BASE,
  parameter int          WSW  = BUS_WSW
) (
  input logic           CLK,
  input logic           RESET,
  bus_responder_if.slave bus
);

  state_e         state_q, state_d;
  logic [WSW-1:0] count_q, count_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [15:0]    wrData_q, wrData_d;
  cyc_e           cycType_q, cycType_d;
  logic           err_q, err_d;

  logic [15:0]    offset;
  logic           inWindow;
  logic           request;
  logic           readActive;
  logic           ramWe;
  logic [AW-1:0]  ramAddr;
  logic [15:0]    ramDout;

  assign offset   = bus.ABUS - BASE;
  assign inWindow = (offset >> AW) == 16'h0;
  assign request  = bus.AOUTENX && (bus.DOUTENX ^ bus.DINENX);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      addr_q    <= '0;
      wrData_q  <= '0;
      cycType_q <= CYC_RD;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      wrData_q  <= wrData_d;
      cycType_q <= cycType_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    addr_d    = addr_q;
    wrData_d  = wrData_q;
    cycType_d = cycType_q;
    err_d     = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (request) begin
          addr_d    = offset[AW-1:0];
          wrData_d  = bus.DBUS_W;
          cycType_d = bus.DOUTENX ? CYC_WR : CYC_RD;
          err_d     = !inWindow;
          count_d   = bus.WAIT_STATES;
          state_d   = (bus.WAIT_STATES != '0) ? ST_WAIT : ST_ACK;
        end else if (bus.AOUTENX) begin
          cycType_d = CYC_ERR;
          err_d     = 1'b1;
          count_d   = '0;
          state_d   = ST_ACK;
        end
      end
      ST_WAIT: begin
        // Dropping the strobe abandons the cycle before any write can commit.
        if (!bus.AOUTENX) begin
          count_d = '0;
          state_d = ST_IDLE;
        end else begin
          count_d = count_q - WSW'(1);
          if (count_q == WSW'(1)) begin
            state_d = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!bus.AOUTENX) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The RAM sees the live bus address in IDLE so a zero-wait read has data by ACK.
  assign ramAddr = (state_q == ST_IDLE) ? offset[AW-1:0] : addr_q;
  assign ramWe   = (state_q == ST_ACK) && (cycType_q == CYC_WR) && !err_q && !RESET;

  bus_ram #(
    .AW(AW),
    .DW(16)
  ) uRam (
    .CLK (CLK),
    .WE  (ramWe),
    .ADDR(ramAddr),
    .DIN (wrData_q),
    .DOUT(ramDout)
  );

  assign readActive    = ((state_q == ST_ACK) || (state_q == ST_HOLD)) && (cycType_q == CYC_RD);
  assign bus.READY     = (state_q == ST_ACK);
  assign bus.BUS_ERR   = (state_q == ST_ACK) && err_q;
  assign bus.DBUS_R_EN = readActive;
  assign bus.DBUS_R    = (readActive && !err_q) ? ramDout : 16'h0000;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: directed protocol scenarios plus
// randomized traffic compared against a word-array memory model.
module tb_bus_responder;
  import bus_pkg::*;

  localparam int          AW     = BUS_AW;
  localparam logic [15:0] BASE   = BUS_BASE;
  localparam int          WINDOW = 2 ** AW;

  typedef struct {
    int          cycles;
    logic        ackErr;
    logic        ackEn;
    logic [15:0] ackData;
    logic        holdReady;
    logic        holdErr;
    logic        holdEn;
    logic [15:0] holdData;
    logic        idleEn;
    logic [15:0] idleData;
  } result_t;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] model [0:WINDOW-1];

  bus_responder_if #(.WSW(BUS_WSW)) bus ();

  bus_responder #(
    .AW  (AW),
    .BASE(BASE),
    .WSW (BUS_WSW)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic idleBus();
    bus.AOUTENX     = 1'b0;
    bus.DOUTENX     = 1'b0;
    bus.DINENX      = 1'b0;
    bus.ABUS        = 16'h0000;
    bus.DBUS_W      = 16'h0000;
    bus.WAIT_STATES = '0;
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, " READY"}, 32'(bus.READY), 32'd0);
    checkOutput({tag, " BUS_ERR"}, 32'(bus.BUS_ERR), 32'd0);
    checkOutput({tag, " DBUS_R_EN"}, 32'(bus.DBUS_R_EN), 32'd0);
    checkOutput({tag, " DBUS_R"}, 32'(bus.DBUS_R), 32'd0);
  endtask

  // Drives one full bus cycle; the address/data/wait inputs are scrambled
  // right after the request edge so they must have been latched.
  task automatic applyStimulus(input logic dout, input logic din, input logic [15:0] addr,
                               input logic [15:0] data, input logic [2:0] ws, output result_t r);
    bus.ABUS        = addr;
    bus.DBUS_W      = data;
    bus.WAIT_STATES = ws;
    bus.AOUTENX     = 1'b1;
    bus.DOUTENX     = dout;
    bus.DINENX      = din;
    step();
    r.cycles        = 1;
    bus.ABUS        = 16'($urandom);
    bus.DBUS_W      = 16'($urandom);
    bus.WAIT_STATES = '0;
    while (!bus.READY && r.cycles < 20) begin
      step();
      r.cycles++;
    end
    if (!bus.READY) r.cycles = -1;
    r.ackErr  = bus.BUS_ERR;
    r.ackEn   = bus.DBUS_R_EN;
    r.ackData = bus.DBUS_R;
    step();
    r.holdReady = bus.READY;
    r.holdErr   = bus.BUS_ERR;
    r.holdEn    = bus.DBUS_R_EN;
    r.holdData  = bus.DBUS_R;
    idleBus();
    step();
    r.idleEn   = bus.DBUS_R_EN;
    r.idleData = bus.DBUS_R;
  endtask

  task automatic runCycle(input string tag, input logic dout, input logic din,
                          input logic [15:0] addr, input logic [15:0] data, input logic [2:0] ws);
    result_t     r;
    logic        proto;
    logic        isRead;
    logic        inWin;
    logic [15:0] off;
    int          expCycles;
    logic        expErr;
    logic        expEn;
    logic [15:0] expData;
    proto     = !(dout ^ din);
    isRead    = din && !dout;
    off       = addr - BASE;
    inWin     = int'(off) < WINDOW;
    expCycles = proto ? 1 : int'(ws) + 1;
    expErr    = proto || !inWin;
    expEn     = !proto && isRead;
    expData   = (expEn && inWin) ? model[off[AW-1:0]] : 16'h0000;
    applyStimulus(dout, din, addr, data, ws, r);
    checkOutput({tag, " cycles"}, 32'(r.cycles), 32'(expCycles));
    checkOutput({tag, " ack BUS_ERR"}, 32'(r.ackErr), 32'(expErr));
    checkOutput({tag, " ack DBUS_R_EN"}, 32'(r.ackEn), 32'(expEn));
    checkOutput({tag, " ack DBUS_R"}, 32'(r.ackData), 32'(expData));
    checkOutput({tag, " hold READY"}, 32'(r.holdReady), 32'd0);
    checkOutput({tag, " hold BUS_ERR"}, 32'(r.holdErr), 32'd0);
    checkOutput({tag, " hold DBUS_R_EN"}, 32'(r.holdEn), 32'(expEn));
    checkOutput({tag, " hold DBUS_R"}, 32'(r.holdData), 32'(expData));
    checkOutput({tag, " idle DBUS_R_EN"}, 32'(r.idleEn), 32'd0);
    checkOutput({tag, " idle DBUS_R"}, 32'(r.idleData), 32'd0);
    if (!proto && dout && inWin) model[off[AW-1:0]] = data;
  endtask

  initial begin
    logic [15:0] addr;
    idleBus();
    RESET = 1'b1;
    step();
    step();
    checkQuiet("reset");
    RESET = 1'b0;

    $display("[TB] zero-wait write then read");
    runCycle("wr beef", 1'b1, 1'b0, 16'h0005, 16'hBEEF, 3'd0);
    runCycle("rd beef", 1'b0, 1'b1, 16'h0005, 16'h0000, 3'd0);

    $display("[TB] wait states");
    runCycle("rd ws3", 1'b0, 1'b1, 16'h0005, 16'h0000, 3'd3);
    runCycle("wr ws7", 1'b1, 1'b0, 16'h0006, 16'hC0DE, 3'd7);
    runCycle("rd ws7", 1'b0, 1'b1, 16'h0006, 16'h0000, 3'd7);

    $display("[TB] abort");
    runCycle("abort pre", 1'b1, 1'b0, 16'h0010, 16'hAAAA, 3'd0);
    bus.ABUS = 16'h0010; bus.DBUS_W = 16'h1234; bus.WAIT_STATES = 3'd5;
    bus.AOUTENX = 1'b1; bus.DOUTENX = 1'b1; bus.DINENX = 1'b0;
    step();
    checkOutput("abort wait0 READY", 32'(bus.READY), 32'd0);
    step();
    checkOutput("abort wait1 READY", 32'(bus.READY), 32'd0);
    step();
    checkOutput("abort wait2 READY", 32'(bus.READY), 32'd0);
    idleBus();
    step();
    checkQuiet("abort drop");
    step();
    checkQuiet("abort after");
    runCycle("abort rd", 1'b0, 1'b1, 16'h0010, 16'h0000, 3'd2);

    $display("[TB] protocol and window errors");
    runCycle("proto pre", 1'b1, 1'b0, 16'h0020, 16'h5555, 3'd1);
    runCycle("proto both", 1'b1, 1'b1, 16'h0020, 16'hDEAD, 3'd5);
    runCycle("proto none", 1'b0, 1'b0, 16'h0020, 16'hDEAD, 3'd2);
    runCycle("proto rd", 1'b0, 1'b1, 16'h0020, 16'h0000, 3'd0);
    runCycle("win rd", 1'b0, 1'b1, BASE + 16'(WINDOW), 16'h0000, 3'd2);
    runCycle("win wr", 1'b1, 1'b0, BASE + 16'(WINDOW) + 16'h0005, 16'h1111, 3'd1);
    runCycle("win alias rd", 1'b0, 1'b1, 16'h0005, 16'h0000, 3'd0);

    $display("[TB] reset mid-cycle");
    runCycle("rst pre", 1'b1, 1'b0, 16'h0030, 16'h7777, 3'd0);
    bus.ABUS = 16'h0030; bus.DBUS_W = 16'h9999; bus.WAIT_STATES = 3'd4;
    bus.AOUTENX = 1'b1; bus.DOUTENX = 1'b1; bus.DINENX = 1'b0;
    step();
    step();
    RESET = 1'b1;
    idleBus();
    step();
    checkQuiet("rst in wait");
    RESET = 1'b0;
    runCycle("rst wait rd", 1'b0, 1'b1, 16'h0030, 16'h0000, 3'd0);
    bus.ABUS = 16'h0030; bus.DBUS_W = 16'h4242; bus.WAIT_STATES = 3'd0;
    bus.AOUTENX = 1'b1; bus.DOUTENX = 1'b1; bus.DINENX = 1'b0;
    step();
    checkOutput("rst ack READY", 32'(bus.READY), 32'd1);
    RESET = 1'b1;
    idleBus();
    step();
    checkQuiet("rst in ack");
    RESET = 1'b0;
    runCycle("rst ack rd", 1'b0, 1'b1, 16'h0030, 16'h0000, 3'd1);

    $display("[TB] back-to-back");
    for (int i = 0; i < 8; i++) begin
      runCycle("b2b wr", 1'b1, 1'b0, 16'(i), 16'($urandom), 3'($urandom_range(0, 7)));
      runCycle("b2b rd", 1'b0, 1'b1, 16'(i), 16'h0000, 3'($urandom_range(0, 7)));
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) addr = BASE + 16'(WINDOW) + 16'($urandom_range(0, 255));
      else addr = BASE + 16'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0)
        runCycle("rnd wr", 1'b1, 1'b0, addr, 16'($urandom), 3'($urandom_range(0, 7)));
      else
        runCycle("rnd rd", 1'b0, 1'b1, addr, 16'h0000, 3'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
